ctrl_seq: RTL

Registered, parametrised control sequencer for the 9-bit CSE141L core. It sits between instrROM and the datapath and replaces purely combinational decode with a one-stage decode register and a small FSM. The FSM adds start/halt sequencing, multi-cycle load stalls, a latched Zero flag for conditional jumps, and optional illegal-opcode trapping. Outputs drive program_counter, reg_file, ALU, data_memory and the top_level write-source mux.

---
 rtl/ctrl_seq.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_seq.sv
// ctrl_seq: registered control sequencer for the 9-bit CSE141L core.
// One-stage decode register plus a four-state FSM: IDLE, RUN, LOAD, HALT.
// The instruction sampled at one edge drives the outputs after the next edge.
// A latched Zero flag (ZF) feeds je/jne. ZF is forwarded from ZeroIn when the
// instruction just ahead of the jump was a flag setter.
// Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, 1111xxxxx
// opcodes other than 9'h1FF trap to HALT with Err = 1. When it is undefined,
// they are nops and Err is tied low.
// Handshake: Start is a level sampled on Clk. It is acted on only in IDLE or
// HALT and ignored elsewhere. Stall = 1 tells the PC to hold, so the
// instruction on Instruction is sampled only at edges that end a Stall = 0
// cycle.
module ctrl_seq #(
  parameter int REG_AW  = 3,
  parameter int MEM_LAT = 2,
  parameter int TGT_W   = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [8:0]        Instruction,
  input  logic              ZeroIn,
  output logic              RegWrEn,
  output logic              MemWrEn,
  output logic [1:0]        WriteSource,
  output logic [REG_AW-1:0] ReadRegAddrA,
  output logic [REG_AW-1:0] ReadRegAddrB,
  output logic [REG_AW-1:0] WriteRegAddr,
  output logic [2:0]        ALUOp,
  output logic              JumpTaken,
  output logic [TGT_W-1:0]  JumpTgt,
  output logic              Stall,
  output logic              Ack,
  output logic              Err,
  output logic [1:0]        dbg_state
);

  localparam logic [2:0] K_LSH = 3'd0, K_RSH = 3'd1, K_XOR = 3'd2, K_RXR = 3'd3;
  localparam logic [2:0] K_ORR = 3'd4, K_ADD = 3'd5, K_SUB = 3'd6;
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LOAD, S_HALT} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] load_cnt, load_cnt_n;
  logic             zf, zf_src, zf_src_n, zf_eff, load_done;

  // Decoded fields of the current Instruction.
  logic              d_wr, d_mw, d_jt, d_ldr, d_halt, d_setzf;
  logic [1:0]        d_ws;
  logic [REG_AW-1:0] d_wa, d_ra, d_rb;
  logic [2:0]        d_alu;
  logic [TGT_W-1:0]  d_tgt;
`ifdef ILLEGAL_TRAP_EN
  logic              d_ill;
`endif

  // Next values of the registered outputs.
  logic              reg_wr_n, mem_wr_n, jump_n, stall_n, ack_n;
  logic [1:0]        ws_n;
  logic [REG_AW-1:0] wa_n, ra_n, rb_n;
  logic [2:0]        alu_n;
  logic [TGT_W-1:0]  tgt_n;

  assign dbg_state = state;
  assign load_done = (load_cnt == LAT_C);
  // A jump right behind a flag setter sees that setter's ZeroIn directly.
  assign zf_eff    = zf_src ? ZeroIn : zf;

  // Instruction decode; fields not used by an opcode stay zero.
  always_comb begin
    d_wr = 1'b0; d_mw = 1'b0; d_jt = 1'b0; d_ldr = 1'b0; d_halt = 1'b0; d_setzf = 1'b0;
    d_ws = 2'b00; d_wa = '0; d_ra = '0; d_rb = '0; d_alu = K_LSH; d_tgt = '0;
`ifdef ILLEGAL_TRAP_EN
    d_ill = 1'b0;
`endif
    if (Instruction[8:7] == 2'b00) begin
      d_wr  = 1'b1;
      d_wa  = REG_AW'(Instruction[5:3]);
      d_ra  = REG_AW'(3'd4);
      d_rb  = REG_AW'(Instruction[2:0]);
      d_alu = Instruction[6] ? K_RSH : K_LSH;
    end else begin
      case (Instruction[8:5])
        4'b0100: begin
          d_ldr = 1'b1; d_ws = 2'b01;
          d_wa  = REG_AW'(Instruction[4:2]);
          d_ra  = REG_AW'({1'b1, Instruction[1:0]});
        end
        4'b0101: begin
          d_mw = 1'b1;
          d_ra = REG_AW'(Instruction[4:2]);
          d_rb = REG_AW'({1'b1, Instruction[1:0]});
        end
        4'b0110: begin
          d_wr = 1'b1; d_setzf = 1'b1; d_alu = K_XOR;
          d_wa = REG_AW'(Instruction[4:2]); d_ra = REG_AW'(Instruction[4:2]);
          d_rb = REG_AW'(3'd4);
        end
        4'b0111: begin
          d_wr = 1'b1; d_setzf = 1'b1; d_alu = K_RXR;
          d_wa = REG_AW'(Instruction[4:2]); d_ra = REG_AW'(Instruction[4:2]);
        end
        4'b1000: begin d_wr = 1'b1; d_ws = 2'b10; d_wa = REG_AW'(Instruction[4:2]); end
        4'b1001: begin d_wr = 1'b1; d_ws = 2'b11; d_wa = REG_AW'(Instruction[4:2]); end
        4'b1010: begin d_jt = zf_eff;  d_tgt = TGT_W'(Instruction[4:0]); end
        4'b1011: begin d_jt = !zf_eff; d_tgt = TGT_W'(Instruction[4:0]); end
        4'b1100: begin
          d_setzf = 1'b1; d_alu = K_SUB;
          d_ra = REG_AW'(Instruction[4:2]); d_rb = REG_AW'(3'd4);
        end
        4'b1101: begin
          d_wr = 1'b1; d_alu = K_ORR;
          d_wa = REG_AW'(Instruction[4:2]); d_ra = REG_AW'(Instruction[4:2]);
          d_rb = REG_AW'({1'b1, Instruction[1:0]});
        end
        4'b1110: begin
          d_wr = 1'b1; d_setzf = 1'b1; d_alu = Instruction[1] ? K_SUB : K_ADD;
          d_wa = REG_AW'(Instruction[4:2]); d_ra = REG_AW'(Instruction[4:2]);
          d_rb = REG_AW'(3'd4);
        end
        4'b1111: begin
          if (Instruction == 9'h1FF) d_halt = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          else d_ill = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // State, load counter and Zero flag registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      load_cnt <= '0;
      zf       <= 1'b0;
      zf_src   <= 1'b0;
    end else begin
      state    <= state_n;
      load_cnt <= load_cnt_n;
      zf_src   <= zf_src_n;
      if (zf_src) zf <= ZeroIn;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n    = state;
    load_cnt_n = load_cnt;
    zf_src_n   = 1'b0;
    case (state)
      S_IDLE: if (Start) state_n = S_RUN;
      S_RUN: begin
        zf_src_n = d_setzf;
        if (d_halt) state_n = S_HALT;
`ifdef ILLEGAL_TRAP_EN
        else if (d_ill) state_n = S_HALT;
`endif
        else if (d_ldr) begin
          state_n    = S_LOAD;
          load_cnt_n = CNT_W'(1);
        end
      end
      S_LOAD: begin
        if (load_done) begin
          state_n    = S_RUN;
          load_cnt_n = '0;
        end else begin
          load_cnt_n = load_cnt + CNT_W'(1);
        end
      end
      S_HALT: if (Start) state_n = S_RUN;
      default: state_n = S_IDLE;
    endcase
  end

  // Output logic: next value of every registered output.
  // Leaving IDLE, HALT or LOAD gives one all-zero cycle, so the PC advances
  // before the next fetch is sampled.
  always_comb begin
    reg_wr_n = 1'b0; mem_wr_n = 1'b0; jump_n = 1'b0; stall_n = 1'b0; ack_n = 1'b0;
    ws_n = 2'b00; wa_n = '0; ra_n = '0; rb_n = '0; alu_n = K_LSH; tgt_n = '0;
    case (state)
      S_IDLE: stall_n = !Start;
      S_RUN: begin
        if (d_halt) begin
          ack_n = 1'b1; stall_n = 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        else if (d_ill) begin
          ack_n = 1'b1; stall_n = 1'b1;
        end
`endif
        else begin
          reg_wr_n = d_ldr ? (MEM_LAT == 1) : d_wr;
          mem_wr_n = d_mw; jump_n = d_jt; stall_n = d_ldr;
          ws_n = d_ws; wa_n = d_wa; ra_n = d_ra; rb_n = d_rb; alu_n = d_alu; tgt_n = d_tgt;
        end
      end
      S_LOAD: begin
        if (!load_done) begin
          stall_n  = 1'b1;
          ws_n = WriteSource; wa_n = WriteRegAddr; ra_n = ReadRegAddrA; rb_n = ReadRegAddrB;
          reg_wr_n = (load_cnt + CNT_W'(1) == LAT_C);
        end
      end
      S_HALT: begin
        ack_n = !Start; stall_n = !Start;
      end
      default: ;
    endcase
  end

  // Decode register driving the datapath.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      RegWrEn <= 1'b0; MemWrEn <= 1'b0; WriteSource <= 2'b00;
      ReadRegAddrA <= '0; ReadRegAddrB <= '0; WriteRegAddr <= '0;
      ALUOp <= K_LSH; JumpTaken <= 1'b0; JumpTgt <= '0; Stall <= 1'b0; Ack <= 1'b0;
    end else begin
      RegWrEn <= reg_wr_n; MemWrEn <= mem_wr_n; WriteSource <= ws_n;
      ReadRegAddrA <= ra_n; ReadRegAddrB <= rb_n; WriteRegAddr <= wa_n;
      ALUOp <= alu_n; JumpTaken <= jump_n; JumpTgt <= tgt_n; Stall <= stall_n; Ack <= ack_n;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic err_n;
  // Err is set by an illegal opcode and cleared by Start out of HALT.
  always_comb begin
    err_n = Err;
    if (state == S_HALT && Start) err_n = 1'b0;
    else if (state == S_RUN && d_ill) err_n = 1'b1;
  end

  // Trap flag register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) Err <= 1'b0;
    else       Err <= err_n;
  end
`else
  assign Err = 1'b0;
`endif

endmodule
